// File: rtl/afe_dac_tx_playback.sv
// Plays 32-bit words from the AFE sample buffer out to the DAC at a programmable sample rate.
// First sample appears rate_div+4 cycles after enable; a staged word waits for a tick, output holds until ready.
module afe_dac_tx_playback #(
  parameter int BUF_AWIDTH     = 10,
  parameter int BUF_TRANS_SIZE = 16,
  parameter int DAC_DATA_WIDTH = 32,
  parameter int RATE_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [BUF_AWIDTH-1:0]     cfg_startaddr_i,
  input  logic [BUF_TRANS_SIZE-1:0] cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic [RATE_WIDTH-1:0]     cfg_rate_div_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic [BUF_AWIDTH-1:0]     cfg_curr_addr_o,
  output logic [BUF_TRANS_SIZE-1:0] cfg_bytes_left_o,
  output logic                      buf_req_o,
  output logic [BUF_AWIDTH-1:0]     buf_addr_o,
  input  logic                      buf_gnt_i,
  input  logic                      buf_rvalid_i,
  input  logic [DAC_DATA_WIDTH-1:0] buf_rdata_i,
  output logic                      dac_tx_valid_o,
  output logic [DAC_DATA_WIDTH-1:0] dac_tx_data_o,
  input  logic                      dac_tx_ready_i,
  output logic                      done_event_o,
  output logic                      underrun_event_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_FULL} state_t;

  localparam logic [BUF_AWIDTH-1:0]     ADDR_STEP = BUF_AWIDTH'(4);
  localparam logic [BUF_TRANS_SIZE-1:0] SIZE_STEP = BUF_TRANS_SIZE'(4);
  localparam logic [RATE_WIDTH-1:0]     DIV_ONE   = RATE_WIDTH'(1);

  state_t                    state_q;
  logic                      en_q;
  logic [BUF_AWIDTH-1:0]     curr_addr_q;
  logic [BUF_TRANS_SIZE-1:0] bytes_left_q;
  logic                      stg_vld_q;
  logic [DAC_DATA_WIDTH-1:0] stg_dat_q;
  logic                      out_vld_q;
  logic [DAC_DATA_WIDTH-1:0] out_dat_q;
  logic                      div_run_q;
  logic [RATE_WIDTH-1:0]     div_cnt_q;
  logic                      done_q;
  logic                      underrun_q;

  logic [BUF_AWIDTH-1:0]     start_word;
  logic [BUF_TRANS_SIZE-1:0] size_word;
  logic                      size_ok;
  logic                      tick;
  logic                      out_acc;
  logic                      move;
  logic                      rdata_take;
  logic                      unused_lsbs;

  assign start_word  = {cfg_startaddr_i[BUF_AWIDTH-1:2], 2'b00};
  assign size_word   = {cfg_size_i[BUF_TRANS_SIZE-1:2], 2'b00};
  assign size_ok     = |cfg_size_i[BUF_TRANS_SIZE-1:2];
  assign unused_lsbs = ^{cfg_startaddr_i[1:0], cfg_size_i[1:0]};

  // A tick only advances data if the output slot is free or being freed this cycle.
  assign tick       = div_run_q && (div_cnt_q == '0);
  assign out_acc    = out_vld_q && dac_tx_ready_i;
  assign move       = tick && stg_vld_q && (!out_vld_q || out_acc);
  assign rdata_take = (state_q == ST_WAIT) && buf_rvalid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      curr_addr_q  <= '0;
      bytes_left_q <= '0;
      stg_vld_q    <= 1'b0;
      stg_dat_q    <= '0;
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
      div_run_q    <= 1'b0;
      div_cnt_q    <= '0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else if (cfg_clr_i) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      bytes_left_q <= '0;
      stg_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      div_run_q    <= 1'b0;
      div_cnt_q    <= '0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= tick && !move;

      if (tick) begin
        div_cnt_q <= cfg_rate_div_i;
      end else if (div_run_q) begin
        div_cnt_q <= div_cnt_q - DIV_ONE;
      end

      if (move) begin
        out_vld_q <= 1'b1;
        out_dat_q <= stg_dat_q;
        stg_vld_q <= 1'b0;
      end else if (out_acc) begin
        out_vld_q <= 1'b0;
      end

      // The divider starts on the first staged word of a run and then free-runs.
      if (rdata_take) begin
        stg_vld_q <= 1'b1;
        stg_dat_q <= buf_rdata_i;
        if (!div_run_q) begin
          div_run_q <= 1'b1;
          div_cnt_q <= cfg_rate_div_i;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cfg_en_i && size_ok) begin
            curr_addr_q  <= start_word;
            bytes_left_q <= size_word;
            en_q         <= 1'b1;
            state_q      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (buf_gnt_i) begin
            curr_addr_q  <= curr_addr_q + ADDR_STEP;
            bytes_left_q <= bytes_left_q - SIZE_STEP;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (buf_rvalid_i) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          // With nothing left to fetch and no reload, FULL doubles as the drain state.
          if (move) begin
            if (bytes_left_q != '0) begin
              state_q <= ST_FETCH;
            end else if (cfg_continuous_i && size_ok) begin
              curr_addr_q  <= start_word;
              bytes_left_q <= size_word;
              state_q      <= ST_FETCH;
            end
          end else if (!stg_vld_q && out_acc) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            done_q    <= 1'b1;
            div_run_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_en_o         = en_q;
  assign cfg_curr_addr_o  = curr_addr_q;
  assign cfg_bytes_left_o = bytes_left_q;
  assign buf_req_o        = (state_q == ST_FETCH);
  assign buf_addr_o       = curr_addr_q;
  assign dac_tx_valid_o   = out_vld_q;
  assign dac_tx_data_o    = out_dat_q;
  assign done_event_o     = done_q;
  assign underrun_event_o = underrun_q;

endmodule

// File: tb/tb_afe_dac_tx_playback.sv
// Bench for afe_dac_tx_playback: random buffer contents, a req/gnt memory responder and a sample scoreboard.
`timescale 1ns/1ps
module tb_afe_dac_tx_playback;
  localparam int AW = 10;
  localparam int SW = 16;
  localparam int DW = 32;
  localparam int RW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] cfg_startaddr_i = '0;
  logic [SW-1:0] cfg_size_i = '0;
  logic          cfg_continuous_i = 1'b0;
  logic [RW-1:0] cfg_rate_div_i = '0;
  logic          cfg_en_i = 1'b0;
  logic          cfg_clr_i = 1'b0;
  logic          cfg_en_o;
  logic [AW-1:0] cfg_curr_addr_o;
  logic [SW-1:0] cfg_bytes_left_o;
  logic          buf_req_o;
  logic [AW-1:0] buf_addr_o;
  logic          buf_gnt_i = 1'b0;
  logic          buf_rvalid_i = 1'b0;
  logic [DW-1:0] buf_rdata_i = '0;
  logic          dac_tx_valid_o;
  logic [DW-1:0] dac_tx_data_o;
  logic          dac_tx_ready_i = 1'b0;
  logic          done_event_o;
  logic          underrun_event_o;

  always #5 clk_i = ~clk_i;

  afe_dac_tx_playback #(
    .BUF_AWIDTH(AW), .BUF_TRANS_SIZE(SW), .DAC_DATA_WIDTH(DW), .RATE_WIDTH(RW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_startaddr_i(cfg_startaddr_i), .cfg_size_i(cfg_size_i),
    .cfg_continuous_i(cfg_continuous_i), .cfg_rate_div_i(cfg_rate_div_i),
    .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i), .cfg_en_o(cfg_en_o),
    .cfg_curr_addr_o(cfg_curr_addr_o), .cfg_bytes_left_o(cfg_bytes_left_o),
    .buf_req_o(buf_req_o), .buf_addr_o(buf_addr_o), .buf_gnt_i(buf_gnt_i),
    .buf_rvalid_i(buf_rvalid_i), .buf_rdata_i(buf_rdata_i),
    .dac_tx_valid_o(dac_tx_valid_o), .dac_tx_data_o(dac_tx_data_o),
    .dac_tx_ready_i(dac_tx_ready_i), .done_event_o(done_event_o),
    .underrun_event_o(underrun_event_o)
  );

  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;
  int gnt_pct = 100;
  int ready_pct = 100;
  logic        pend = 1'b0;
  logic [7:0]  pend_idx = '0;
  int cyc = 0;
  int en_cyc = 0;
  int first_vld_cyc = -1;
  int done_cnt = 0;
  int und_cnt = 0;
  logic [31:0] got_q [$];
  int          got_cyc [$];
  logic [9:0]  fetch_q [$];
  logic        prev_vld = 1'b0, prev_acc = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, prev_abort = 1'b1;
  logic [31:0] prev_dat = '0;
  logic [9:0]  prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory responder, handshake protocol checks and sample/event logging, all mid-cycle.
  always @(negedge clk_i) begin
    cyc++;
    buf_rvalid_i   = pend;
    buf_rdata_i    = pend ? mem[pend_idx] : $urandom();
    buf_gnt_i      = (int'($urandom_range(0, 99)) < gnt_pct);
    dac_tx_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
    pend           = buf_req_o && buf_gnt_i;
    pend_idx       = buf_addr_o[9:2];
    if (!prev_abort) begin
      if (prev_req && !prev_gnt) begin
        chk("req_hold", 32'(buf_req_o), 32'd1);
        chk("addr_hold", 32'(buf_addr_o), 32'(prev_addr));
      end
      if (prev_vld && !prev_acc) begin
        chk("vld_hold", 32'(dac_tx_valid_o), 32'd1);
        chk("dat_hold", dac_tx_data_o, prev_dat);
      end
    end
    if (cfg_en_i) en_cyc = cyc;
    if (dac_tx_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (buf_req_o && buf_gnt_i) fetch_q.push_back(buf_addr_o);
    if (dac_tx_valid_o && dac_tx_ready_i) begin
      got_q.push_back(dac_tx_data_o);
      got_cyc.push_back(cyc);
    end
    if (done_event_o) done_cnt++;
    if (underrun_event_o) und_cnt++;
    prev_vld   = dac_tx_valid_o;
    prev_acc   = dac_tx_valid_o && dac_tx_ready_i;
    prev_dat   = dac_tx_data_o;
    prev_req   = buf_req_o;
    prev_gnt   = buf_gnt_i;
    prev_addr  = buf_addr_o;
    prev_abort = rst_i || cfg_clr_i;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic start_run(input logic [9:0] start, input logic [15:0] size,
                           input logic [15:0] rate, input logic cont);
    got_q.delete();
    got_cyc.delete();
    fetch_q.delete();
    done_cnt = 0;
    und_cnt = 0;
    first_vld_cyc = -1;
    cfg_startaddr_i  = start;
    cfg_size_i       = size;
    cfg_rate_div_i   = rate;
    cfg_continuous_i = cont;
    cfg_en_i = 1'b1;
    step(1);
    cfg_en_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!dac_tx_valid_o && i < 200) begin
      step(1);
      i++;
    end
    chk({tag, "_vld_seen"}, 32'(dac_tx_valid_o), 32'd1);
  endtask

  // Expected stream: consecutive words from the aligned start address, wrapping in the buffer.
  task automatic finish_run(input string tag, input logic [9:0] start, input logic [15:0] size);
    int n;
    logic [9:0] a;
    logic [9:0] a_end;
    n = int'(size[15:2]);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) step(1);
    step(2);
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_nsamp"}, 32'(got_q.size()), 32'(n));
    chk({tag, "_nfetch"}, 32'(fetch_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = {start[9:2], 2'b00} + 10'(4 * i);
      if (i < got_q.size()) chk({tag, "_dat"}, got_q[i], mem[a[9:2]]);
      if (i < fetch_q.size()) chk({tag, "_addr"}, 32'(fetch_q[i]), 32'(a));
    end
    a_end = {start[9:2], 2'b00} + {size[9:2], 2'b00};
    chk({tag, "_en_off"}, 32'(cfg_en_o), 32'd0);
    chk({tag, "_left"}, 32'(cfg_bytes_left_o), 32'd0);
    chk({tag, "_curr"}, 32'(cfg_curr_addr_o), 32'(a_end));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(cfg_en_o), 32'd0);
    chk({tag, "_req"}, 32'(buf_req_o), 32'd0);
    chk({tag, "_addr"}, 32'(buf_addr_o), 32'd0);
    chk({tag, "_curr"}, 32'(cfg_curr_addr_o), 32'd0);
    chk({tag, "_left"}, 32'(cfg_bytes_left_o), 32'd0);
    chk({tag, "_vld"}, 32'(dac_tx_valid_o), 32'd0);
    chk({tag, "_dat"}, dac_tx_data_o, 32'd0);
    chk({tag, "_evt"}, 32'({done_event_o, underrun_event_o}), 32'd0);
  endtask

  initial begin
    logic [9:0]  s;
    logic [15:0] z;
    logic [15:0] rd;
    logic [9:0]  a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();

    step(3);
    chk_all_zero("reset");
    rst_i = 1'b0;
    step(2);

    // Single run: 4 words paced every 8 cycles
    start_run(10'h040, 16'd16, 16'd7, 1'b0);
    finish_run("single", 10'h040, 16'd16);
    chk("single_latency", 32'(first_vld_cyc - en_cyc), 32'd11);
    for (int i = 1; i < got_cyc.size(); i++)
      chk("single_gap", 32'(got_cyc[i] - got_cyc[i-1]), 32'd8);
    chk("single_und", 32'(und_cnt), 32'd0);

    // Continuous wrap across the top of the buffer
    start_run(10'h3F8, 16'd16, 16'd3, 1'b1);
    for (int i = 0; i < 2000 && fetch_q.size() < 13; i++) step(1);
    cfg_clr_i = 1'b1;
    step(1);
    cfg_clr_i = 1'b0;
    cfg_continuous_i = 1'b0;
    chk("cont_nfetch", 32'(fetch_q.size() >= 13), 32'd1);
    chk("cont_ngot", 32'(got_q.size() >= 9), 32'd1);
    for (int i = 0; i < fetch_q.size(); i++) begin
      a = 10'h3F8 + 10'(4 * (i % 4));
      chk("cont_addr", 32'(fetch_q[i]), 32'(a));
    end
    for (int i = 0; i < got_q.size(); i++) begin
      a = 10'h3F8 + 10'(4 * (i % 4));
      chk("cont_dat", got_q[i], mem[a[9:2]]);
    end
    chk("cont_done", 32'(done_cnt), 32'd0);
    chk("cont_und", 32'(und_cnt), 32'd0);
    chk("cont_en_off", 32'(cfg_en_o), 32'd0);
    step(5);

    // DAC backpressure: 20 stalled cycles at period 4 miss exactly 5 ticks
    start_run(10'h080, 16'd32, 16'd3, 1'b0);
    wait_valid("bp");
    ready_pct = 0;
    step(20);
    ready_pct = 100;
    finish_run("bp", 10'h080, 16'd32);
    chk("bp_und", 32'(und_cnt), 32'd5);

    // Grant stall: 10 cycles without grant at period 3 miss exactly 4 ticks
    start_run(10'h200, 16'd32, 16'd2, 1'b0);
    wait_valid("gs");
    gnt_pct = 0;
    step(10);
    gnt_pct = 100;
    finish_run("gs", 10'h200, 16'd32);
    chk("gs_und", 32'(und_cnt), 32'd4);

    // Abort in the grant cycle (rvalid lands after clear) and in WAIT (rvalid with clear)
    for (int v = 0; v < 2; v++) begin
      start_run(10'h100, 16'd16, 16'd20, 1'b0);
      if (v == 0) begin
        for (int i = 0; i < 20 && !pend; i++) step(1);
      end
      cfg_clr_i = 1'b1;
      step(1);
      cfg_clr_i = 1'b0;
      chk("clr_en", 32'(cfg_en_o), 32'd0);
      chk("clr_vld", 32'(dac_tx_valid_o), 32'd0);
      chk("clr_left", 32'(cfg_bytes_left_o), 32'd0);
      chk("clr_req", 32'(buf_req_o), 32'd0);
      step(40);
      chk("clr_nsamp", 32'(got_q.size()), 32'd0);
      chk("clr_done", 32'(done_cnt), 32'd0);
      start_run(10'h300, 16'd12, 16'd3, 1'b0);
      finish_run("restart", 10'h300, 16'd12);
    end

    // Reset while a word is staged, then a too-small size is ignored
    start_run(10'h000, 16'd16, 16'd20, 1'b0);
    step(3);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk_all_zero("midrst");
    cfg_size_i = 16'd3;
    cfg_en_i = 1'b1;
    step(1);
    cfg_en_i = 1'b0;
    step(2);
    chk("size3_en", 32'(cfg_en_o), 32'd0);
    chk("size3_req", 32'(buf_req_o), 32'd0);
    chk("size3_left", 32'(cfg_bytes_left_o), 32'd0);

    // Random runs under random grant and ready throttling
    for (int r = 0; r < 6; r++) begin
      s  = 10'($urandom());
      z  = 16'($urandom_range(4, 64));
      rd = 16'($urandom_range(2, 9));
      gnt_pct   = int'($urandom_range(60, 100));
      ready_pct = int'($urandom_range(50, 100));
      start_run(s, z, rd, 1'b0);
      finish_run("rand", s, z);
      gnt_pct   = 100;
      ready_pct = 100;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
